seq_divider: RTL and testbench

//  Iterative signed divider: the inverse of the signed multiplier. Accepts a
//  2*BIT_WIDTH-bit dividend (product width) and a BIT_WIDTH-bit divisor and

---
 rtl/seq_divider_pkg.sv | 28 ++
 rtl/seq_divider_abs_value.sv | 17 +
 rtl/seq_divider.sv | 188 ++++++++++++++++++
 tb/tb_seq_divider.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and width/saturation helpers for seq_divider
`timescale 1ns/1ps
package seq_divider_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Largest positive value of a bw-bit signed number
  function automatic int sat_max(input int bw);
    return (1 << (bw - 1)) - 1;
  endfunction

  // Most negative value of a bw-bit signed number
  function automatic int sat_min(input int bw);
    return -(1 << (bw - 1));
  endfunction

  // Iteration counter width: one quotient bit per dividend bit
  function automatic int cnt_width(input int bw);
    return $clog2(2 * bw);
  endfunction

endpackage

// File: rtl/seq_divider_abs_value.sv
// rtl/seq_divider_abs_value.sv - two's-complement value to unsigned magnitude plus sign
`timescale 1ns/1ps
module abs_value #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] magnitude,
  output logic         negative
);

  // The most negative input maps to 2^(W-1), which still fits W unsigned bits
  always_comb begin
    negative  = value[W-1];
    magnitude = negative ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative signed restoring divider, 2*BW dividend by BW divisor
`timescale 1ns/1ps
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*BIT_WIDTH-1:0]   dividend,
  input  logic [BIT_WIDTH-1:0]     divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_WIDTH-1:0]     quotient,
  output logic [BIT_WIDTH-1:0]     remainder,
  output logic                     overflow,
  output logic                     div_by_zero
);

  localparam int BW = BIT_WIDTH;
  localparam int DW = 2 * BIT_WIDTH;
  localparam int CW = cnt_width(BIT_WIDTH);

  localparam logic [BW-1:0] SAT_MAX = BW'(sat_max(BW));
  localparam logic [BW-1:0] SAT_MIN = BW'(sat_min(BW));
  localparam logic [CW-1:0] LAST    = CW'(DW - 1);

  // Quotient magnitude limits, widened to the dividend width for comparison
  localparam logic [DW-1:0] POS_LIM = {{(DW-BW){1'b0}}, SAT_MAX};
  localparam logic [DW-1:0] NEG_LIM = POS_LIM + {{(DW-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] count;
  logic [BW-1:0] rem_q;      // partial remainder, always < |divisor|
  logic [DW-1:0] dvd_q;      // dividend magnitude shifting out, quotient shifting in
  logic [BW-1:0] dvs_q;      // divisor magnitude
  logic          neg_q;      // quotient sign
  logic          dvd_neg_q;  // remainder sign (follows dividend)

  logic [DW-1:0] dvd_mag;
  logic          dvd_neg;
  logic [BW-1:0] dvs_mag;
  logic          dvs_neg;

  logic accept;
  logic dvs_zero;
  logic dvd_zero;

  logic [BW:0]   rem_shift;
  logic          q_bit;
  logic [BW-1:0] rem_nxt;

  logic [BW-1:0] fix_q;
  logic [BW-1:0] fix_r;
  logic          fix_ov;

  abs_value #(.W(DW)) u_abs_dividend (
    .value     (dividend),
    .magnitude (dvd_mag),
    .negative  (dvd_neg)
  );

  abs_value #(.W(BW)) u_abs_divisor (
    .value     (divisor),
    .magnitude (dvs_mag),
    .negative  (dvs_neg)
  );

  assign accept   = in_valid && in_ready;
  assign dvs_zero = (divisor == '0);
  assign dvd_zero = (dividend == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: zero operands skip the iteration and go straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (dvs_zero || dvd_zero) ? ST_DONE : ST_CALC;
      ST_CALC: if (count == LAST) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // One restoring step: the shifted remainder needs BW+1 bits before the compare
  always_comb begin
    rem_shift = {rem_q, dvd_q[DW-1]};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_nxt   = q_bit ? BW'(rem_shift - {1'b0, dvs_q}) : rem_shift[BW-1:0];
  end

  // Sign restoration and saturation; a negative result may reach one step further
  always_comb begin
    fix_ov = 1'b0;
    fix_q  = dvd_q[BW-1:0];
    if (!neg_q) begin
      fix_ov = (dvd_q > POS_LIM);
      fix_q  = fix_ov ? SAT_MAX : dvd_q[BW-1:0];
    end else begin
      fix_ov = (dvd_q > NEG_LIM);
      fix_q  = fix_ov ? SAT_MIN : (~dvd_q[BW-1:0] + {{(BW-1){1'b0}}, 1'b1});
    end
    fix_r = dvd_neg_q ? (~rem_q + {{(BW-1){1'b0}}, 1'b1}) : rem_q;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      dvd_neg_q   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            count     <= '0;
            rem_q     <= '0;
            dvd_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            neg_q     <= dvd_neg ^ dvs_neg;
            dvd_neg_q <= dvd_neg;
            remainder <= '0;
            overflow  <= 1'b0;
            if (dvs_zero) begin
              div_by_zero <= 1'b1;
              quotient    <= dvd_neg ? SAT_MIN : SAT_MAX;
            end else begin
              div_by_zero <= 1'b0;
              quotient    <= '0;
            end
          end
        end
        ST_CALC: begin
          rem_q <= rem_nxt;
          dvd_q <= {dvd_q[DW-2:0], q_bit};
          count <= count + CW'(1);
        end
        ST_FIX: begin
          quotient    <= fix_q;
          remainder   <= fix_r;
          overflow    <= fix_ov;
          div_by_zero <= 1'b0;
        end
        ST_DONE: begin
          if (out_ready) begin
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against an arithmetic model
`timescale 1ns/1ps
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        overflow;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.BIT_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: integer / and % truncate toward zero, then saturate to 8-bit signed
  function automatic void model(input int d, input int v, output int q, output int r,
                                output int ov, output int dz, output int lat);
    int tq;
    if (v == 0) begin
      q = (d >= 0) ? 127 : -128; r = 0; ov = 0; dz = 1; lat = 1;
    end else if (d == 0) begin
      q = 0; r = 0; ov = 0; dz = 0; lat = 1;
    end else begin
      tq  = d / v;
      r   = d % v;
      dz  = 0;
      lat = 18;
      ov  = (tq > 127 || tq < -128) ? 1 : 0;
      q   = (tq > 127) ? 127 : ((tq < -128) ? -128 : tq);
    end
  endfunction

  // Called at a negedge; issues one operation and consumes exactly one result
  task automatic run_op(input int d, input int v, input int in_gap, input int rdy_gap, input bit extra);
    int q, r, ov, dz, lat, nlat;
    bit ok;
    model(d, v, q, r, ov, dz, lat);
    repeat (in_gap) @(negedge clk);
    dividend = 16'(d);
    divisor  = 8'(v);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    ok = 1'b0;
    nlat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (extra) begin
          dividend = 16'h1234;
          divisor  = 8'h05;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin ok = 1'b1; nlat = k; break; end
    end
    if (!ok) begin
      check("done_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    check("latency", nlat, lat);
    for (int g = 0; g < rdy_gap; g++) begin
      check("hold_q", $signed(quotient), q);
      check("hold_r", $signed(remainder), r);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("quotient", $signed(quotient), q);
    check("remainder", $signed(remainder), r);
    check("overflow", int'(overflow), ov);
    check("div_by_zero", int'(div_by_zero), dz);
    check("out_valid", int'(out_valid), 1);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_in_ready", int'(in_ready), 1);
    check("post_out_valid", int'(out_valid), 0);
    check("post_flags", int'({overflow, div_by_zero}), 0);
  endtask

  initial begin
    logic signed [15:0] t16;
    logic signed [7:0]  t8;
    int d, v, mode;

    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_flags", int'({overflow, div_by_zero}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(-1000, 9, 0, 0, 1'b0);
    run_op(1000, 7, 0, 0, 1'b0);
    run_op(-32768, -1, 1, 0, 1'b0);
    run_op(16384, -128, 0, 0, 1'b0);
    run_op(500, 0, 0, 0, 1'b0);
    run_op(0, -5, 0, 0, 1'b0);
    run_op(-500, 0, 0, 2, 1'b1);
    run_op(100, 3, 0, 5, 1'b1);

    // Abort an operation partway through the iteration
    dividend = 16'd1000;
    divisor  = 8'd9;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin check("abort_spurious_result", 1, 0); break; end
    end
    run_op(-7, 2, 0, 0, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      t16  = 16'($urandom);
      t8   = 8'($urandom);
      d    = t16;
      v    = t8;
      mode = $urandom_range(0, 9);
      case (mode)
        0: v = 0;
        1: d = 0;
        2: d = -32768;
        3: v = ($urandom_range(0, 1) != 0) ? -128 : -1;
        default: d = d >>> $urandom_range(0, 10);
      endcase
      run_op(d, v, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
